// File: rtl/data_mem_pkg.sv
// Shared definitions for the data memory and the LSU that drives it:
// store-size codes (RISC-V store funct3) and the byte-laned word type.
package data_mem_pkg;

    localparam int DMEM_WORD_W = 32;
    localparam int DMEM_LANES  = DMEM_WORD_W / 8;

    localparam logic [2:0] ST_SB = 3'b000;
    localparam logic [2:0] ST_SH = 3'b001;
    localparam logic [2:0] ST_SW = 3'b010;

    typedef logic [DMEM_LANES-1:0][7:0] dmem_word_t;
    typedef logic [DMEM_LANES-1:0]      dmem_mask_t;

endpackage

// File: rtl/dmem_strb_decode.sv
// Turns a store-size code plus write enable into a per-byte-lane write mask.
// Sub-word stores always land in the low lanes of the word.
module dmem_strb_decode
    import data_mem_pkg::*;
(
    input  logic [2:0] wr_strb_i,
    input  logic       we_i,
    output dmem_mask_t lane_mask_o
);

    // NOTE: lane_mask_o is given a default before the case so that every path assigns it and no latch is inferred.
    always_comb begin
        lane_mask_o = '0;
        if (we_i) begin
            unique case (wr_strb_i)
                ST_SB:   lane_mask_o = 4'b0001;
                ST_SH:   lane_mask_o = 4'b0011;
                ST_SW:   lane_mask_o = 4'b1111;
                default: lane_mask_o = 4'b0000;
            endcase
        end
    end

endmodule

// File: rtl/data_mem.sv
// Word-organised data memory: one byte-masked write port, one combinational
// full-word read port, whole array cleared asynchronously by rst.
module data_mem
    import data_mem_pkg::*;
#(
    parameter  int DEPTH  = 16,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ADDR_W-1:0]      rd_addr0,
    input  logic [ADDR_W-1:0]      wr_addr0,
    input  logic [DMEM_WORD_W-1:0] wr_din0,
    input  logic                   we0,
    input  logic [2:0]             wr_strb,
    output logic [DMEM_WORD_W-1:0] rd_dout0
);

    dmem_word_t mem_q [DEPTH];
    dmem_word_t wr_word_d;
    dmem_mask_t lane_mask;
    logic       wr_in_range;
    logic       rd_in_range;
    logic       wr_en;

    dmem_strb_decode u_strb_decode (
        .wr_strb_i   (wr_strb),
        .we_i        (we0),
        .lane_mask_o (lane_mask)
    );

    // Address range guards only cost logic when DEPTH leaves unused codes.
    if (DEPTH < (1 << ADDR_W)) begin : g_partial
        assign wr_in_range = (32'(wr_addr0) < 32'(DEPTH));
        assign rd_in_range = (32'(rd_addr0) < 32'(DEPTH));
    end else begin : g_full
        assign wr_in_range = 1'b1;
        assign rd_in_range = 1'b1;
    end

    assign wr_en = (|lane_mask) && wr_in_range;

    always_comb begin
        wr_word_d = mem_q[wr_addr0];
        for (int b = 0; b < DMEM_LANES; b++) begin
            if (lane_mask[b]) begin
                wr_word_d[b] = wr_din0[8*b +: 8];
            end
        end
    end

    // NOTE: the array is reset explicitly because rd_dout0 must never be X after reset; this keeps it in flops, not RAM macros.
    // NOTE: state updates use <= so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[wr_addr0] <= wr_word_d;
        end
    end

    assign rd_dout0 = rd_in_range ? mem_q[rd_addr0] : '0;

endmodule

// File: tb/tb_data_mem.sv
// Scoreboard bench for data_mem: stimulus pushes expected read words from a
// plain array model; a monitor pops and compares one sample per read request.
module tb_data_mem;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = $clog2(DEPTH);

    logic              clk;
    logic              rst;
    logic [ADDR_W-1:0] rd_addr0;
    logic [ADDR_W-1:0] wr_addr0;
    logic [31:0]       wr_din0;
    logic              we0;
    logic [2:0]        wr_strb;
    logic [31:0]       rd_dout0;

    data_mem #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .rd_addr0 (rd_addr0),
        .wr_addr0 (wr_addr0),
        .wr_din0  (wr_din0),
        .we0      (we0),
        .wr_strb  (wr_strb),
        .rd_dout0 (rd_dout0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] model [DEPTH];
    logic [31:0] exp_q [$];
    string       name_q [$];
    event        rd_ev;
    int          total = 0;
    int          bad   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h want %08h", nm, act, exp);
        end
    endtask

    // Monitor: one sample, 1 ns after each read request settles.
    initial begin
        forever begin
            @(rd_ev);
            #1;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL scoreboard_underflow: got read with no expectation");
            end else begin
                check(name_q.pop_front(), rd_dout0, exp_q.pop_front());
            end
        end
    end

    task automatic expect_rd(input int a, input string nm);
        rd_addr0 = ADDR_W'(a);
        exp_q.push_back(model[a]);
        name_q.push_back(nm);
        ->rd_ev;
        #2;
    endtask

    function automatic void model_store(input int a, input logic [31:0] d,
                                        input logic [2:0] strb, input logic we);
        if (!we) return;
        case (strb)
            3'd0: model[a] = {model[a][31:8], d[7:0]};
            3'd1: model[a] = {model[a][31:16], d[15:0]};
            3'd2: model[a] = d;
            default: ;
        endcase
    endfunction

    task automatic do_write(input int a, input logic [31:0] d,
                            input logic [2:0] strb, input logic we);
        @(negedge clk);
        wr_addr0 = ADDR_W'(a);
        wr_din0  = d;
        wr_strb  = strb;
        we0      = we;
        @(posedge clk);
        if (!rst) model_store(a, d, strb, we);
        #1;
        we0 = 1'b0;
    endtask

    task automatic clear_model();
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
    endtask

    initial begin
        rst      = 1'b1;
        rd_addr0 = '0;
        wr_addr0 = '0;
        wr_din0  = '0;
        we0      = 1'b0;
        wr_strb  = 3'd2;
        clear_model();

        #12;
        expect_rd(7, "in_reset_read");
        #16;
        rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) expect_rd(i, "reset_value");

        do_write(0, 32'hF0F0_0F0F, 3'd2, 1'b1);
        expect_rd(0, "sw_addr0");
        expect_rd(1, "sw_neighbour");

        do_write(3, 32'h1122_3344, 3'd2, 1'b1);
        do_write(3, 32'hAAAA_AABB, 3'd0, 1'b1);
        expect_rd(3, "sb_low_lane");
        do_write(3, 32'h0000_CCDD, 3'd1, 1'b1);
        expect_rd(3, "sh_low_half");

        do_write(0, 32'hDEAD_BEEF, 3'd4, 1'b1);
        expect_rd(0, "bad_strb_ignored");
        do_write(0, 32'hDEAD_BEEF, 3'd2, 1'b0);
        expect_rd(0, "we0_low_ignored");

        // Same-address: old value before the edge, new value after it.
        @(negedge clk);
        wr_addr0 = 4'd5;
        wr_din0  = 32'h1234_5678;
        wr_strb  = 3'd2;
        we0      = 1'b1;
        expect_rd(5, "same_addr_before_edge");
        @(posedge clk);
        model_store(5, 32'h1234_5678, 3'd2, 1'b1);
        #1;
        we0 = 1'b0;
        expect_rd(5, "same_addr_after_edge");

        // Randomised mix of stores, including invalid codes and we0=0.
        for (int n = 0; n < 300; n++) begin
            automatic int          a    = $urandom_range(DEPTH - 1);
            automatic logic [31:0] d    = $urandom;
            automatic logic [2:0]  strb = 3'($urandom_range(7));
            automatic logic        we   = ($urandom_range(3) != 0);
            do_write(a, d, strb, we);
            expect_rd($urandom_range(DEPTH - 1), "rand_read");
            expect_rd(a, "rand_readback");
        end

        // Mid-operation async reset between edges, then a write under reset.
        do_write(2, 32'hCAFE_F00D, 3'd2, 1'b1);
        expect_rd(2, "pre_reset_word");
        @(negedge clk);
        #1;
        rst = 1'b1;
        clear_model();
        #1;
        expect_rd(2, "async_reset_clear");
        do_write(2, 32'h5555_AAAA, 3'd2, 1'b1);
        expect_rd(2, "write_blocked_in_reset");
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) expect_rd(i, "post_reset_value");

        #5;
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
